// File: rtl/seg7_capture.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus with per-digit stability filtering.
// Optional macro SEG7_CAPTURE_ERR_EN builds the illegal-pattern / ghosting error flag.
module seg7_capture #(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample,
  input  logic [NDIG-1:0]   an,
  input  logic [1:7]        seg,
  output logic [4*NDIG-1:0] digits,
  output logic              frame_valid,
  output logic              err,
  input  logic              err_clr
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int LW = $clog2(NDIG + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE - 1);

  // Returns {legal, value}; segment order is A (MSB) through G (LSB).
  function automatic logic [4:0] decode(input logic [1:7] s);
    case (s)
      7'b0000001: decode = {1'b1, 4'd0};
      7'b1001111: decode = {1'b1, 4'd1};
      7'b0010010: decode = {1'b1, 4'd2};
      7'b0000110: decode = {1'b1, 4'd3};
      7'b1001100: decode = {1'b1, 4'd4};
      7'b0100100: decode = {1'b1, 4'd5};
      7'b0100000: decode = {1'b1, 4'd6};
      7'b0001111: decode = {1'b1, 4'd7};
      7'b0000000: decode = {1'b1, 4'd8};
      7'b0000100: decode = {1'b1, 4'd9};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  logic [NDIG-1:0] en;
  logic [LW-1:0]   nlow;
  logic            accept;
  logic            ghost;
  logic            legal;
  logic [3:0]      code;

  assign en = ~an;

  always_comb begin
    nlow = '0;
    for (int i = 0; i < NDIG; i++) begin
      nlow = nlow + LW'(en[i]);
    end
    accept = sample && (nlow == LW'(1));
    ghost  = sample && (nlow > LW'(1));
    {legal, code} = decode(seg);
  end

  logic [NDIG-1:0][3:0]    last_q, last_d;
  logic [NDIG-1:0][3:0]    dig_q, dig_d;
  logic [NDIG-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NDIG-1:0]         seen_q, seen_nx, commit;

  // A continuing run commits only on the step that reaches STABLE; a fresh run commits only when STABLE is 1.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    commit = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (accept && en[i]) begin
        if (!legal) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] != '0 && code == last_q[i]) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
          commit[i] = (cnt_q[i] == CNT_PRE);
        end else begin
          last_d[i] = code;
          cnt_d[i]  = CW'(1);
          commit[i] = (STABLE == 1);
        end
        if (commit[i]) dig_d[i] = code;
      end
    end
    seen_nx = seen_q | commit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= '0;
      cnt_q       <= '0;
      dig_q       <= '0;
      seen_q      <= '0;
      frame_valid <= 1'b0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      if (&seen_nx) begin
        frame_valid <= 1'b1;
        seen_q      <= '0;
      end else begin
        frame_valid <= 1'b0;
        seen_q      <= seen_nx;
      end
    end
  end

  assign digits = dig_q;

`ifdef SEG7_CAPTURE_ERR_EN
  logic err_q;
  logic err_event;

  assign err_event = ghost || (accept && !legal);

  // Set has priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (err_event) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  logic unused_err;

  assign unused_err = ^{err_clr, ghost};
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized self-checking bench for seg7_capture against a run-length reference model.
module tb_seg7_capture;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;
`ifdef SEG7_CAPTURE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sample;
  logic [3:0]  an;
  logic [1:7]  seg;
  logic        err_clr;
  logic [15:0] digits;
  logic        frame_valid;
  logic        err;

  seg7_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .sample(sample), .an(an), .seg(seg),
    .digits(digits), .frame_valid(frame_valid), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int n_vec = 0;
  int n_err = 0;

  // Reference model: unbounded run lengths, committing when a run reaches exactly STABLE.
  int          m_run  [NDIG];
  int          m_last [NDIG];
  logic [15:0] m_digits;
  logic [3:0]  m_seen;
  logic        m_fv;
  logic        m_err;

  function automatic int seg_value(input logic [6:0] s);
    seg_value = -1;
    for (int k = 0; k < 10; k++) if (pat[k] == s) seg_value = k;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin
      m_run[i]  = 0;
      m_last[i] = 0;
    end
    m_digits = '0;
    m_seen   = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step();
    int  lows;
    int  sel;
    int  v;
    logic ev;
    lows = 0;
    sel  = 0;
    ev   = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!an[i]) begin
        lows++;
        sel = i;
      end
    end
    if (sample && lows == 1) begin
      v = seg_value(seg);
      if (v < 0) begin
        m_run[sel] = 0;
        ev = 1'b1;
      end else begin
        if (m_run[sel] > 0 && v == m_last[sel]) m_run[sel]++;
        else begin
          m_last[sel] = v;
          m_run[sel]  = 1;
        end
        if (m_run[sel] == STABLE) begin
          m_digits[4*sel +: 4] = 4'(v);
          m_seen[sel] = 1'b1;
        end
      end
    end
    if (sample && lows >= 2) ev = 1'b1;
    if (m_seen == 4'hF) begin
      m_fv   = 1'b1;
      m_seen = '0;
    end else begin
      m_fv = 1'b0;
    end
    if (ERR_EN) begin
      if (ev) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  endtask

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("digits", digits, m_digits);
    check_output("frame_valid", 16'(frame_valid), 16'(m_fv));
    check_output("err", 16'(err), 16'(m_err));
  end

  // One clock cycle with the given bus values; the model steps on the same edge as the DUT.
  task automatic apply_stimulus(input logic s, input logic [3:0] a, input logic [6:0] sg, input logic clr);
    sample  = s;
    an      = a;
    seg     = sg;
    err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
    sample  = 1'b0;
    an      = 4'hF;
    seg     = 7'h7F;
    err_clr = 1'b0;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 4'hF, 7'h7F, 1'b0);
  endtask

  task automatic put(input int d, input int v);
    apply_stimulus(1'b1, ~(4'(1) << d), pat[v], 1'b0);
  endtask

  task automatic commit_digit(input int d, input int v);
    for (int k = 0; k < STABLE; k++) put(d, v);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_rst_digits", digits, 16'h0000);
    check_output("async_rst_fv", 16'(frame_valid), 16'h0);
    check_output("async_rst_err", 16'(err), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] glitch_exp [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd5};
  int         glitch_val [6] = '{5, 5, 6, 5, 5, 5};

  initial begin
    int         tgt [NDIG];
    int         d;
    int         d2;
    int         r;
    logic       s;
    logic [3:0] a;
    logic [6:0] sg;
    logic       clr;

    rst_n = 1'b0;
    sample = 1'b0;
    an = 4'hF;
    seg = 7'h7F;
    err_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full frame: digits 1,2,3,4 on positions 0..3; pulse only after the 12th sample.
    for (int i = 0; i < NDIG; i++) begin
      for (int k = 0; k < STABLE; k++) begin
        put(i, i + 1);
        check_output("frame_pulse", 16'(frame_valid), (i == 3 && k == 2) ? 16'h1 : 16'h0);
      end
    end
    check_output("frame_digits", digits, 16'h4321);
    idle();
    check_output("frame_pulse_end", 16'(frame_valid), 16'h0);

    put(0, 7);
    put(0, 7);
    do_reset();

    // Glitch filter on digit 0.
    for (int k = 0; k < 6; k++) begin
      put(0, glitch_val[k]);
      check_output("glitch_d0", 16'(digits[3:0]), 16'(glitch_exp[k]));
    end

    // Illegal pattern breaks the run on digit 1 and raises err.
    put(1, 5);
    put(1, 5);
    apply_stimulus(1'b1, 4'b1101, 7'b1111111, 1'b0);
    check_output("illegal_err", 16'(err), 16'(ERR_EN));
    put(1, 5);
    put(1, 5);
    check_output("illegal_run_reset", 16'(digits[7:4]), 16'h0);
    put(1, 5);
    check_output("illegal_recommit", 16'(digits[7:4]), 16'h5);
    apply_stimulus(1'b0, 4'hF, 7'h7F, 1'b1);
    check_output("err_clr", 16'(err), 16'h0);
    apply_stimulus(1'b1, 4'b1110, 7'b1111111, 1'b1);
    check_output("err_set_wins", 16'(err), 16'(ERR_EN));
    apply_stimulus(1'b0, 4'hF, 7'h7F, 1'b1);

    // Ghosting and blanking.
    apply_stimulus(1'b1, 4'b1100, pat[8], 1'b0);
    check_output("ghost_digits", digits, 16'h0055);
    check_output("ghost_err", 16'(err), 16'(ERR_EN));
    apply_stimulus(1'b0, 4'hF, 7'h7F, 1'b1);
    apply_stimulus(1'b1, 4'b1111, pat[8], 1'b0);
    check_output("blank_digits", digits, 16'h0055);
    check_output("blank_err", 16'(err), 16'h0);

    // Reset mid-frame discards partial progress.
    do_reset();
    commit_digit(0, 9);
    commit_digit(1, 8);
    do_reset();
    commit_digit(2, 7);
    commit_digit(3, 6);
    check_output("midframe_no_fv", 16'(frame_valid), 16'h0);
    commit_digit(0, 9);
    check_output("midframe_no_fv2", 16'(frame_valid), 16'h0);
    commit_digit(1, 8);
    check_output("midframe_fv", 16'(frame_valid), 16'h1);
    check_output("midframe_digits", digits, 16'h6789);
    idle();

    // Randomized traffic with slowly changing per-digit targets.
    for (int i = 0; i < NDIG; i++) tgt[i] = i;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      s = ($urandom_range(0, 99) < 85);
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 3);
      if (r < 7) a = ~(4'(1) << d);
      else if (r == 7) a = 4'hF;
      else begin
        d2 = (d + 1 + $urandom_range(0, 2)) % 4;
        a = ~((4'(1) << d) | (4'(1) << d2));
      end
      if ($urandom_range(0, 9) == 0) tgt[d] = $urandom_range(0, 9);
      if ($urandom_range(0, 99) < 90) sg = pat[tgt[d]];
      else sg = 7'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      apply_stimulus(s, a, sg, clr);
    end
    repeat (3) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
# seg7_capture

Recovers BCD digits from a multiplexed, active-low 7-segment display bus; the inverse of the team's BCD-to-segment driver. It is used on the UPC package detector board to read back the digit and segment lines a display controller drives. Each observation is decoded and filtered for stability per digit. Once every digit position has committed a stable value, the block presents a full numeric frame.

## Interface
Parameters:
- `NDIG`, default 4: number of multiplexed digit positions.
- `STABLE`, default 3: consecutive identical legal observations required to commit a digit (≥1).

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `sample`, in, 1: observation strobe. The bus is looked at only in cycles where `sample`=1.
- `an`, in, NDIG: active-low digit enables.
- `seg`, in, [1:7]: active-low segments, bit 1=A through bit 7=G (0 = lit).
- `digits`, out, 4*NDIG: committed BCD values; digit i occupies `digits[4i+3:4i]`.
- `frame_valid`, out, 1: one-cycle pulse when all NDIG positions have committed since the last pulse.
- `err`, out, 1: sticky error flag (see Configuration).
- `err_clr`, in, 1: synchronous clear of `err`.

## Operation
- **Accepted sample:** `sample`=1 and exactly one bit of `an` is 0. That bit selects digit i.
- **Ignored cycles:**
  - `sample`=1 with `an` all ones (blanked) is ignored.
  - `sample`=1 with two or more `an` bits at 0 (ghosting) is ignored for decoding and counts as an error event.
- **Decode map (ABCDEFG → value):**
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - Any other pattern is illegal.
- **Per-digit state:** `last[i]` (4 bits) and `cnt[i]` (0..STABLE, saturating). `cnt[i]`=0 means no run in progress.
- **Legal accepted sample, code c, digit i:**
  - If `cnt[i]`>0 and c==`last[i]`: `cnt[i]` increments, saturating at STABLE.
  - Otherwise: `last[i]`←c and `cnt[i]`←1.
  - Commit happens when the updated count equals STABLE and the previous count was not STABLE within the same run. On commit, `digits[i]`←c and `seen[i]`←1.
  - A saturated run does not re-commit.
  - With STABLE=1, every new run commits immediately.
- **Illegal accepted sample on digit i:** `cnt[i]`←0, `last[i]` is unchanged, `digits[i]` is unchanged, and it counts as an error event.
- **Frame:**
  - When the next value of `seen` is all ones, `frame_valid`←1 and `seen`←0 on that same edge.
  - Otherwise `frame_valid`←0.
  - Re-committing an already-seen digit within a frame updates `digits` without side effects.
- **`err` update:**
  - Set on any error event.
  - Cleared by `err_clr`.
  - If an error event and `err_clr` occur in the same cycle, set wins.

## Timing
- **Reset values:** `digits`=0, `frame_valid`=0, `err`=0, all `cnt`=0, `last`=0, `seen`=0.
- **Commit latency:** `digits[i]` changes on the clock edge that samples the STABLE-th matching observation.
- **Frame latency:** `frame_valid` is high for exactly the one cycle following that same edge, when that commit completes the frame. `digits` is already final during that cycle.
- **Reset mid-frame:** discards partial `seen` and all runs. No `frame_valid` pulse occurs until all NDIG positions commit again after reset.
- **Input timing:** `an`/`seg` are assumed synchronous to `clk`. Synchronisers are external.
- **Throughput:** the block sustains one accepted sample per cycle.

## Configuration
- **Macro:** `SEG7_CAPTURE_ERR_EN`.
- **Defined:** illegal-pattern and ghosting detection drive `err` as specified above.
- **Undefined:**
  - Error detection logic is not built and `err` is tied to 0.
  - `err_clr` is ignored.
  - Illegal patterns still reset `cnt[i]`.
  - Ghosting samples are still ignored.

## Test plan
Tests use NDIG=4, STABLE=3.
- **Reset:** assert `rst_n`=0 mid-run → `digits`=16'h0000, `frame_valid`=0, `err`=0 immediately (asynchronous).
- **Full frame:** three samples each of `an`=1110/`seg`=1001111, `an`=1101/`seg`=0010010, `an`=1011/`seg`=0000110, `an`=0111/`seg`=1001100 → `digits`=16'h4321. `frame_valid` is high exactly one cycle, following the 12th sample.
- **Glitch filter:** digit 0 sequence 5,5,6,5,5,5 → `digits[3:0]` never shows 6; it becomes 5 at the 6th sample; `cnt` path verified.
- **Illegal pattern:** `an`=1110, `seg`=1111111 → `err`=1 and run reset. `err_clr` alone → `err`=0. Illegal sample plus `err_clr` in the same cycle → `err`=1.
- **Ghosting and blank:**
  - `an`=1100 → `digits` unchanged; `err`=1 with the macro defined, 0 without.
  - `an`=1111 → no effect.
- **Reset mid-frame:** commit digits 0 and 1, pulse `rst_n` low, then commit only digits 2 and 3 → no `frame_valid`. Then commit digits 0 and 1 → one `frame_valid` pulse.
